mac_share_sched: RTL and testbench

- Packet-level scheduler that shares one mac_rtl-style MAC kernel between NUM_REQ requesters.
- Each requester presents a stream of (a, b, c) beats terminated by last. The scheduler grants one requester round-robin and pulses the MAC's ap_start. It then forwards that requester's beats to the MAC's three input streams and routes MAC results back to the granted requester.
- It waits for the MAC's ap_done before granting the next packet.
- Sits between the kernel's per-channel input adapters and the MAC kernel instance.

---
 rtl/mac_share_sched_pkg.sv | 17 +
 rtl/mac_share_sched_if.sv | 53 +++++
 rtl/mac_share_sched_rr_arbiter.sv | 43 ++++
 rtl/mac_share_sched.sv | 116 +++++++++++
 tb/tb_mac_share_sched.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_share_sched_pkg.sv
// rtl/mac_share_sched_pkg.sv - shared types, widths and helpers for the MAC share scheduler
package mac_sched_pkg;

  typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} sched_state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_A_W         = 8;
  localparam int DEF_B_W         = 8;
  localparam int DEF_C_W         = 16;
  localparam int DEF_MAC_TDATA_W = 1024;

  // Grant id width; never below one bit so two requesters still get a real id.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_share_sched_if.sv
// rtl/mac_share_sched_if.sv - requester-side and MAC-side bundles for the MAC share scheduler
interface mac_share_sched_req_if #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 8,
  parameter int B_W     = 8,
  parameter int C_W     = 16
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ*C_W-1:0] req_c;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     res_valid;
  logic [NUM_REQ-1:0]     res_ready;
  logic [C_W-1:0]         res_data;
  logic                   res_last;

  modport master (output req_valid, req_a, req_b, req_c, req_last, res_ready,
                  input  req_ready, res_valid, res_data, res_last);
  modport slave  (input  req_valid, req_a, req_b, req_c, req_last, res_ready,
                  output req_ready, res_valid, res_data, res_last);
endinterface

interface mac_share_sched_mac_if #(
  parameter int MAC_TDATA_W = 1024
);
  logic                     mac_ap_start;
  logic                     mac_ap_done;
  logic                     mac_ap_idle;
  logic                     mac_a_tvalid, mac_b_tvalid, mac_c_tvalid;
  logic                     mac_a_tready, mac_b_tready, mac_c_tready;
  logic [MAC_TDATA_W-1:0]   mac_a_tdata, mac_b_tdata, mac_c_tdata;
  logic [MAC_TDATA_W/8-1:0] mac_a_tkeep, mac_b_tkeep, mac_c_tkeep;
  logic                     mac_a_tlast, mac_b_tlast, mac_c_tlast;
  logic                     mac_out_tvalid;
  logic                     mac_out_tready;
  logic [MAC_TDATA_W-1:0]   mac_out_tdata;
  logic                     mac_out_tlast;

  modport master (output mac_ap_start, mac_a_tvalid, mac_b_tvalid, mac_c_tvalid,
                         mac_a_tdata, mac_b_tdata, mac_c_tdata,
                         mac_a_tkeep, mac_b_tkeep, mac_c_tkeep,
                         mac_a_tlast, mac_b_tlast, mac_c_tlast, mac_out_tready,
                  input  mac_ap_done, mac_ap_idle, mac_a_tready, mac_b_tready, mac_c_tready,
                         mac_out_tvalid, mac_out_tdata, mac_out_tlast);
  modport slave  (input  mac_ap_start, mac_a_tvalid, mac_b_tvalid, mac_c_tvalid,
                         mac_a_tdata, mac_b_tdata, mac_c_tdata,
                         mac_a_tkeep, mac_b_tkeep, mac_c_tkeep,
                         mac_a_tlast, mac_b_tlast, mac_c_tlast, mac_out_tready,
                  output mac_ap_done, mac_ap_idle, mac_a_tready, mac_b_tready, mac_c_tready,
                         mac_out_tvalid, mac_out_tdata, mac_out_tlast);
endinterface

// File: rtl/mac_share_sched_rr_arbiter.sv
// rtl/mac_share_sched_rr_arbiter.sv - round-robin pick over the request vector plus the rotating pointer
module mac_rr_arbiter
  import mac_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(DEF_NUM_REQ)
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv_en,
  input  logic [ID_W-1:0]    adv_id,
  output logic [ID_W-1:0]    win_id,
  output logic               any_req
);

  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr <= '0;
    end else if (adv_en) begin
      rr_ptr <= (int'(adv_id) == NUM_REQ - 1) ? '0 : adv_id + 1'b1;
    end
  end

  // Wrap by subtraction so non-power-of-two NUM_REQ never probes a missing channel.
  always_comb begin
    int idx;
    idx     = 0;
    win_id  = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mac_share_sched.sv
// rtl/mac_share_sched.sv - packet-level round-robin sharing of one MAC kernel between requesters
module mac_share_sched
  import mac_sched_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int A_W         = DEF_A_W,
  parameter int B_W         = DEF_B_W,
  parameter int C_W         = DEF_C_W,
  parameter int MAC_TDATA_W = DEF_MAC_TDATA_W,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  mac_share_sched_req_if.slave rq,
  mac_share_sched_mac_if.master mac,
  output logic                 busy,
  output logic [ID_W-1:0]      gnt_id,
  output logic                 pkt_done
);

  sched_state_t    state_q, state_d;
  logic [ID_W-1:0] gnt_q, win_id;
  logic            any_req, adv;
  logic            sel_valid, sel_last, in_ready;
  logic [A_W-1:0]  sel_a;
  logic [B_W-1:0]  sel_b;
  logic [C_W-1:0]  sel_c;
  logic            unused_ok;

  mac_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .req     (rq.req_valid),
    .adv_en  (adv),
    .adv_id  (gnt_q),
    .win_id  (win_id),
    .any_req (any_req)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) gnt_q <= win_id;
    end
  end

  assign sel_valid = rq.req_valid[gnt_q];
  assign sel_last  = rq.req_last[gnt_q];
  assign sel_a     = rq.req_a[int'(gnt_q)*A_W +: A_W];
  assign sel_b     = rq.req_b[int'(gnt_q)*B_W +: B_W];
  assign sel_c     = rq.req_c[int'(gnt_q)*C_W +: C_W];
  assign in_ready  = mac.mac_a_tready & mac.mac_b_tready & mac.mac_c_tready;

  always_comb begin
    state_d            = state_q;
    adv                = 1'b0;
    pkt_done           = 1'b0;
    mac.mac_ap_start   = 1'b0;
    mac.mac_a_tvalid   = 1'b0;
    mac.mac_b_tvalid   = 1'b0;
    mac.mac_c_tvalid   = 1'b0;
    mac.mac_a_tlast    = 1'b0;
    mac.mac_b_tlast    = 1'b0;
    mac.mac_c_tlast    = 1'b0;
    mac.mac_out_tready = 1'b0;
    rq.req_ready       = '0;
    rq.res_valid       = '0;
    case (state_q)
      IDLE:   if (any_req) state_d = START;
      START: begin
        mac.mac_ap_start = 1'b1;
        state_d          = STREAM;
      end
      STREAM: begin
        mac.mac_a_tvalid = sel_valid;
        mac.mac_b_tvalid = sel_valid;
        mac.mac_c_tvalid = sel_valid;
        mac.mac_a_tlast  = sel_last;
        mac.mac_b_tlast  = sel_last;
        mac.mac_c_tlast  = sel_last;
        rq.req_ready[gnt_q] = in_ready;
        if (sel_valid && in_ready && sel_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (mac.mac_ap_done) begin
          pkt_done = 1'b1;
          adv      = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Results can overtake the input stream, so routing is live from STREAM onward.
    if (state_q == STREAM || state_q == DRAIN) begin
      rq.res_valid[gnt_q] = mac.mac_out_tvalid;
      mac.mac_out_tready  = rq.res_ready[gnt_q];
    end
  end

  assign mac.mac_a_tdata = {{(MAC_TDATA_W-A_W){1'b0}}, sel_a};
  assign mac.mac_b_tdata = {{(MAC_TDATA_W-B_W){1'b0}}, sel_b};
  assign mac.mac_c_tdata = {{(MAC_TDATA_W-C_W){1'b0}}, sel_c};
  assign mac.mac_a_tkeep = '1;
  assign mac.mac_b_tkeep = '1;
  assign mac.mac_c_tkeep = '1;

  assign rq.res_data = mac.mac_out_tdata[C_W-1:0];
  assign rq.res_last = mac.mac_out_tlast;
  assign busy        = (state_q != IDLE);
  assign gnt_id      = gnt_q;
  assign unused_ok   = ^{mac.mac_ap_idle, mac.mac_out_tdata[MAC_TDATA_W-1:C_W]};

endmodule

// File: tb/tb_mac_share_sched.sv
// tb/tb_mac_share_sched.sv - directed bench for mac_share_sched with a small MAC kernel stand-in
module tb_mac_share_sched;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  mac_share_sched_req_if #(.NUM_REQ(4)) rq ();
  mac_share_sched_mac_if #(.MAC_TDATA_W(1024)) mq ();
  logic       busy, pkt_done;
  logic [1:0] gnt_id;

  mac_share_sched #(.NUM_REQ(4), .MAC_TDATA_W(1024)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .rq(rq), .mac(mq),
    .busy(busy), .gnt_id(gnt_id), .pkt_done(pkt_done)
  );

  mac_share_sched_req_if #(.NUM_REQ(3)) rq3 ();
  mac_share_sched_mac_if #(.MAC_TDATA_W(32)) mq3 ();
  logic       busy3, pkt_done3, done3;
  logic [1:0] gnt3;

  mac_share_sched #(.NUM_REQ(3), .MAC_TDATA_W(32)) dut3 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .rq(rq3), .mac(mq3),
    .busy(busy3), .gnt_id(gnt3), .pkt_done(pkt_done3)
  );

  assign mq3.mac_a_tready   = 1'b1;
  assign mq3.mac_b_tready   = 1'b1;
  assign mq3.mac_c_tready   = 1'b1;
  assign mq3.mac_out_tvalid = 1'b0;
  assign mq3.mac_out_tdata  = '0;
  assign mq3.mac_out_tlast  = 1'b0;
  assign mq3.mac_ap_idle    = 1'b1;
  assign mq3.mac_ap_done    = done3;

  // MAC stand-in: two-deep result queue, stalls inputs when full, done after the last result leaves.
  logic [15:0] fq_d [0:3];
  logic        fq_l [0:3];
  int          wp, rp, cnt;
  logic        done_r;

  function automatic logic [15:0] mac16(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
    logic [31:0] f;
    f = {24'b0, a} * {24'b0, b} + {16'b0, c};
    return f[15:0];
  endfunction

  assign mq.mac_a_tready   = (cnt < 2);
  assign mq.mac_b_tready   = (cnt < 2);
  assign mq.mac_c_tready   = (cnt < 2);
  assign mq.mac_out_tvalid = (cnt > 0);
  assign mq.mac_out_tdata  = (cnt > 0) ? {1008'b0, fq_d[rp]} : '0;
  assign mq.mac_out_tlast  = (cnt > 0) ? fq_l[rp] : 1'b0;
  assign mq.mac_ap_done    = done_r;
  assign mq.mac_ap_idle    = (cnt == 0);

  always @(posedge ap_clk) begin
    logic push, pop;
    push = mq.mac_a_tvalid && mq.mac_b_tvalid && mq.mac_c_tvalid && (cnt < 2);
    pop  = (cnt > 0) && mq.mac_out_tready;
    if (ap_rst) begin
      wp <= 0; rp <= 0; cnt <= 0; done_r <= 1'b0;
    end else begin
      if (push) begin
        fq_d[wp] <= mac16(mq.mac_a_tdata[7:0], mq.mac_b_tdata[7:0], mq.mac_c_tdata[15:0]);
        fq_l[wp] <= mq.mac_a_tlast;
        wp       <= (wp + 1) % 4;
      end
      if (pop) rp <= (rp + 1) % 4;
      cnt    <= cnt + (push ? 1 : 0) - (pop ? 1 : 0);
      done_r <= pop && fq_l[rp];
    end
  end

  int res_d[$];
  int res_c[$];
  int res_l[$];
  int gnt_log[$];
  int done_cnt;
  int errors = 0;
  int checks = 0;

  always @(posedge ap_clk) begin
    if (!ap_rst) begin
      for (int i = 0; i < 4; i++) begin
        if (rq.res_valid[i] && rq.res_ready[i]) begin
          res_d.push_back(int'(rq.res_data));
          res_c.push_back(i);
          res_l.push_back(int'(rq.res_last));
        end
      end
      if (mq.mac_ap_start) gnt_log.push_back(int'(gnt_id));
      if (pkt_done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    res_d.delete(); res_c.delete(); res_l.delete(); gnt_log.delete();
    done_cnt = 0;
  endtask

  task automatic send_beat(input int ch, input int a, input int b, input int c, input bit last);
    bit ok;
    ok = 1'b0;
    rq.req_valid[ch]       = 1'b1;
    rq.req_last[ch]        = last;
    rq.req_a[ch*8 +: 8]    = 8'(a);
    rq.req_b[ch*8 +: 8]    = 8'(b);
    rq.req_c[ch*16 +: 16]  = 16'(c);
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge ap_clk);
      if (rq.req_ready[ch]) ok = 1'b1;
    end
    if (!ok) chk($sformatf("handshake_ch%0d", ch), 64'(ok), 64'd1);
    @(posedge ap_clk); #1;
    rq.req_valid[ch] = 1'b0;
    rq.req_last[ch]  = 1'b0;
  endtask

  task automatic wait_pkts(input int n);
    for (int t = 0; t < 500 && done_cnt < n; t++) @(negedge ap_clk);
    chk("pkt_wait", 64'(done_cnt >= n), 64'd1);
  endtask

  initial begin
    bit held;
    rq.req_valid = '0; rq.req_last = '0; rq.req_a = '0; rq.req_b = '0; rq.req_c = '0;
    rq.res_ready = '1;
    rq3.req_valid = '0; rq3.req_last = '0; rq3.req_a = '0; rq3.req_b = '0; rq3.req_c = '0;
    rq3.res_ready = '1;
    done3 = 1'b0;
    clr_log();
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("reset_busy_start", 64'({busy, mq.mac_ap_start, pkt_done}), 64'd0);
    chk("reset_req_ready", 64'(rq.req_ready), 64'd0);
    @(posedge ap_clk); #1 ap_rst = 1'b0;

    // Single requester, three beats
    clr_log();
    send_beat(0, 3, 4, 5, 0);
    send_beat(0, 2, 2, 0, 0);
    send_beat(0, 10, 10, 1, 1);
    wait_pkts(1);
    chk("t1_count", 64'(res_d.size()), 64'd3);
    chk("t1_r0", 64'(res_d[0]), 64'd17);
    chk("t1_r1", 64'(res_d[1]), 64'd4);
    chk("t1_r2", 64'(res_d[2]), 64'd101);
    chk("t1_lasts", 64'({res_l[0][0], res_l[1][0], res_l[2][0]}), 64'b001);
    chk("t1_owner", 64'(res_c[2]), 64'd0);
    chk("t1_starts", 64'(gnt_log.size()), 64'd1);
    chk("t1_done", 64'(done_cnt), 64'd1);

    // All four requesters from reset
    @(posedge ap_clk); #1 ap_rst = 1'b1;
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    clr_log();
    fork
      send_beat(0, 1, 1, 0, 1);
      send_beat(1, 2, 1, 0, 1);
      send_beat(2, 3, 1, 0, 1);
      send_beat(3, 4, 1, 0, 1);
    join
    wait_pkts(4);
    chk("t2_starts", 64'(gnt_log.size()), 64'd4);
    chk("t2_order", 64'({gnt_log[0][1:0], gnt_log[1][1:0], gnt_log[2][1:0], gnt_log[3][1:0]}), 64'b00_01_10_11);
    chk("t2_res_ch3", 64'({res_c[3][7:0], res_d[3][7:0]}), 64'h0304);
    clr_log();
    fork
      send_beat(1, 1, 1, 1, 1);
      send_beat(3, 1, 1, 3, 1);
    join
    wait_pkts(2);
    chk("t2_reorder", 64'({gnt_log.size() == 2, gnt_log[0][1:0], gnt_log[1][1:0]}), 64'b1_01_11);

    // Result backpressure on ch0
    clr_log();
    rq.res_ready[0] = 1'b0;
    fork
      begin
        send_beat(0, 1, 1, 0, 0);
        send_beat(0, 2, 3, 1, 0);
        send_beat(0, 4, 4, 4, 0);
        send_beat(0, 5, 5, 5, 1);
      end
      begin
        for (int t = 0; t < 100 && !rq.res_valid[0]; t++) @(negedge ap_clk);
        held = 1'b1;
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge ap_clk);
          held = held & rq.res_valid[0] & !mq.mac_out_tready;
        end
        chk("t3_held", 64'(held), 64'd1);
        chk("t3_data_held", 64'(rq.res_data), 64'd1);
        chk("t3_in_stall", 64'(rq.req_ready[0]), 64'd0);
        @(posedge ap_clk); #1 rq.res_ready[0] = 1'b1;
      end
    join
    wait_pkts(1);
    chk("t3_count", 64'(res_d.size()), 64'd4);
    chk("t3_data", 64'({res_d[0][7:0], res_d[1][7:0], res_d[2][7:0], res_d[3][7:0]}), 64'h01_07_14_1E);
    chk("t3_last", 64'({res_l[2][0], res_l[3][0]}), 64'b01);

    // Modulo-2^16 wrap in the kernel
    clr_log();
    send_beat(2, 255, 255, 65535, 1);
    wait_pkts(1);
    chk("t4_wrap", 64'(res_d[0]), 64'd65024);
    chk("t4_owner_last", 64'({res_c[0][3:0], res_l[0][3:0]}), 64'h21);

    // Reset mid-STREAM after two of four beats
    send_beat(1, 1, 1, 1, 0);
    send_beat(1, 2, 2, 2, 0);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("t5_ctrl_zero", 64'({busy, pkt_done, mq.mac_ap_start, mq.mac_a_tvalid, mq.mac_b_tvalid,
                             mq.mac_c_tvalid, mq.mac_out_tready, rq.res_last}), 64'd0);
    chk("t5_vectors_zero", 64'({rq.req_ready, rq.res_valid, gnt_id, rq.res_data}), 64'd0);
    chk("t5_rr_ptr", 64'(dut.u_arb.rr_ptr), 64'd0);
    chk("t5_tkeep", 64'(mq.mac_a_tkeep[63:0]), 64'hFFFF_FFFF_FFFF_FFFF);
    clr_log();
    @(posedge ap_clk); #1;
    rq.req_valid[2] = 1'b1; rq.req_last[2] = 1'b1;
    rq.req_a[23:16] = 8'd3; rq.req_b[23:16] = 8'd3; rq.req_c[47:32] = 16'd3;
    @(negedge ap_clk);
    chk("t5_idle_first", 64'({busy, mq.mac_ap_start}), 64'd0);
    @(negedge ap_clk);
    chk("t5_start", 64'({mq.mac_ap_start, gnt_id}), 64'b1_10);
    @(negedge ap_clk);
    chk("t5_stream", 64'({mq.mac_ap_start, rq.req_ready}), 64'b0_0100);
    @(posedge ap_clk); #1;
    rq.req_valid[2] = 1'b0; rq.req_last[2] = 1'b0;
    wait_pkts(1);
    chk("t5_result", 64'(res_d[0]), 64'd12);

    // Three-requester wrap of the pointer
    @(posedge ap_clk); #1;
    rq3.req_valid = 3'b100; rq3.req_last = 3'b100;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    chk("t6_ch2_stream", 64'({gnt3, rq3.req_ready}), 64'b10_100);
    @(posedge ap_clk); #1;
    rq3.req_valid = 3'b000; rq3.req_last = 3'b000;
    done3 = 1'b1;
    @(posedge ap_clk); #1;
    done3 = 1'b0;
    rq3.req_valid = 3'b011;
    @(negedge ap_clk);
    chk("t6_rr_wrap", 64'({busy3, dut3.u_arb.rr_ptr}), 64'd0);
    @(negedge ap_clk);
    chk("t6_ch0_wins", 64'({mq3.mac_ap_start, gnt3}), 64'b1_00);
    @(posedge ap_clk); #1;
    rq3.req_valid = 3'b000;
    repeat (3) @(negedge ap_clk);
    chk("t6_valid_drop", 64'({busy3, mq3.mac_a_tvalid, gnt3}), 64'b1_0_00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
